// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 compression core: one 512-bit block per 64/UNROLL+2 cycles,
// with on-the-fly message schedule and IV / external chaining-value select.
module sha256_iter_core #(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         use_iv,
  input  logic [0:255] hash_constants,
  input  logic [0:511] unhashed_value,
  output logic         busy,
  output logic         done,
  output logic [0:255] hashed_value
);

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NUM_ROUNDS = 64;
  localparam int unsigned CNT_W      = 6;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_ROUNDS - UNROLL);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha256_iter_core: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [WORD_W-1:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [WORD_W-1:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] bsig0(input logic [WORD_W-1:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [WORD_W-1:0] bsig1(input logic [WORD_W-1:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // One compression round; v[0..7] hold a..h.
  function automatic logic [7:0][WORD_W-1:0] round_f(input logic [7:0][WORD_W-1:0] v,
                                                      input logic [WORD_W-1:0] k,
                                                      input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] t1;
    logic [WORD_W-1:0] t2;
    t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + w;
    t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    round_f[7] = v[6];
    round_f[6] = v[5];
    round_f[5] = v[4];
    round_f[4] = v[3] + t1;
    round_f[3] = v[2];
    round_f[2] = v[1];
    round_f[1] = v[0];
    round_f[0] = t1 + t2;
  endfunction

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          w_accept;
  logic                          w_step;
  logic                          w_final;
  logic                          r_busy;
  logic                          r_done;
  logic [0:255]                  r_digest;
  logic [CNT_W-1:0]              r_round;
  logic [7:0][WORD_W-1:0]        r_h;
  logic [7:0][WORD_W-1:0]        r_v;
  logic [15:0][WORD_W-1:0]       r_w;
  logic [7:0][WORD_W-1:0]        w_cv;
  logic [15+UNROLL:0][WORD_W-1:0] w_ext;
  logic [UNROLL:0][7:0][WORD_W-1:0] w_chain;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_final     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        w_step = 1'b1;
        if (r_round == LAST_STEP) w_state_nxt = S_FINAL;
      end
      S_FINAL: begin
        w_final     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Chaining-value select and the UNROLL-deep schedule/round chain.
  always_comb begin
    w_cv    = '0;
    w_ext   = '0;
    w_chain = '0;
    for (int unsigned i = 0; i < 8; i++)
      w_cv[i] = use_iv ? IV[i] : hash_constants[WORD_W*i +: WORD_W];
    w_ext[15:0] = r_w;
    for (int unsigned j = 0; j < UNROLL; j++)
      w_ext[16+j] = ssig1(w_ext[14+j]) + w_ext[9+j] + ssig0(w_ext[1+j]) + w_ext[j];
    w_chain[0] = r_v;
    for (int unsigned j = 0; j < UNROLL; j++)
      w_chain[j+1] = round_f(w_chain[j], K[CNT_W'(r_round + CNT_W'(j))], w_ext[j]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_digest <= '0;
      r_round  <= '0;
    end else begin
      r_done <= w_final;
      if (w_accept) begin
        r_busy  <= 1'b1;
        r_round <= '0;
      end
      if (w_step) r_round <= r_round + CNT_W'(UNROLL);
      if (w_final) begin
        r_busy <= 1'b0;
        for (int unsigned i = 0; i < 8; i++)
          r_digest[WORD_W*i +: WORD_W] <= r_h[i] + r_v[i];
      end
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_h <= w_cv;
      r_v <= w_cv;
      for (int unsigned k = 0; k < 16; k++)
        r_w[k] <= unhashed_value[WORD_W*k +: WORD_W];
    end else if (w_step) begin
      r_v <= w_chain[UNROLL];
      r_w <= w_ext[UNROLL +: 16];
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign hashed_value = r_digest;

endmodule

// File: tb/tb_sha256_iter_core.sv
// Directed bench for sha256_iter_core: known SHA-256 vectors, latency per UNROLL,
// chaining, back-to-back starts, reset abort and input-stability checks.
module tb_sha256_iter_core;

  localparam logic [0:255] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [0:255] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [0:255] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [0:511] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [0:511] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [0:511] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [0:511] B_TWO2  = {480'h0, 32'h000001c0};

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         use_iv;
  logic [0:255] hc;
  logic [0:511] uv;
  logic         bz [4];
  logic         dn [4];
  logic [0:255] hv [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sha256_iter_core #(.UNROLL(1)) u_core1 (.clk(clk), .rst(rst), .start(start), .use_iv(use_iv),
    .hash_constants(hc), .unhashed_value(uv), .busy(bz[0]), .done(dn[0]), .hashed_value(hv[0]));
  sha256_iter_core #(.UNROLL(2)) u_core2 (.clk(clk), .rst(rst), .start(start), .use_iv(use_iv),
    .hash_constants(hc), .unhashed_value(uv), .busy(bz[1]), .done(dn[1]), .hashed_value(hv[1]));
  sha256_iter_core #(.UNROLL(4)) u_core4 (.clk(clk), .rst(rst), .start(start), .use_iv(use_iv),
    .hash_constants(hc), .unhashed_value(uv), .busy(bz[2]), .done(dn[2]), .hashed_value(hv[2]));
  sha256_iter_core #(.UNROLL(8)) u_core8 (.clk(clk), .rst(rst), .start(start), .use_iv(use_iv),
    .hash_constants(hc), .unhashed_value(uv), .busy(bz[3]), .done(dn[3]), .hashed_value(hv[3]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start is already high; returns cycles from the start cycle until done (-1 on timeout).
  task automatic run_block(input int idx, input int bound, input bit scramble, output int lat);
    tick;
    start = 1'b0;
    if (scramble) begin
      uv     = ~uv;
      hc     = {8{32'hdeadbeef}};
      use_iv = ~use_iv;
    end
    lat = 1;
    while (!dn[idx] && lat < bound) begin
      tick;
      lat++;
    end
    if (!dn[idx]) lat = -1;
  endtask

  initial begin
    int           lat;
    int           first [4];
    int           cnt   [4];
    int           nd;
    logic [0:255] h1;
    bit           exp_done;

    rst    = 1'b1;
    start  = 1'b0;
    use_iv = 1'b1;
    hc     = '0;
    uv     = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("reset_busy", 256'(bz[0]), 256'd0);
    chk("reset_done", 256'(dn[0]), 256'd0);
    chk("reset_digest", hv[0], 256'd0);
    chk("reset_digest_u8", hv[3], 256'd0);

    // "abc" with the IV, UNROLL=1
    uv = B_ABC; use_iv = 1'b1; start = 1'b1;
    run_block(0, 100, 1'b0, lat);
    chk("abc_latency", 256'(lat), 256'd66);
    chk("abc_digest", hv[0], D_ABC);
    chk("abc_busy_in_done", 256'(bz[0]), 256'd0);
    tick;
    chk("abc_done_pulse", 256'(dn[0]), 256'd0);
    chk("abc_digest_held", hv[0], D_ABC);

    // Empty message on every UNROLL value
    for (int k = 0; k < 4; k++) begin first[k] = -1; cnt[k] = 0; end
    uv = B_EMPTY; use_iv = 1'b1; start = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick;
      start = 1'b0;
      for (int k = 0; k < 4; k++)
        if (dn[k]) begin
          cnt[k]++;
          if (first[k] < 0) first[k] = i;
        end
    end
    chk("empty_lat_u1", 256'(first[0]), 256'd66);
    chk("empty_lat_u2", 256'(first[1]), 256'd34);
    chk("empty_lat_u4", 256'(first[2]), 256'd18);
    chk("empty_lat_u8", 256'(first[3]), 256'd10);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("empty_done_count_%0d", k), 256'(cnt[k]), 256'd1);
      chk($sformatf("empty_digest_%0d", k), hv[k], D_EMPTY);
    end

    // Two-block chaining; block-2 inputs are scrambled right after accept
    uv = B_TWO1; use_iv = 1'b1; start = 1'b1;
    run_block(0, 100, 1'b0, lat);
    chk("two_blk1_latency", 256'(lat), 256'd66);
    h1 = hv[0];
    uv = B_TWO2; hc = h1; use_iv = 1'b0; start = 1'b1;
    run_block(0, 100, 1'b1, lat);
    chk("two_blk2_latency", 256'(lat), 256'd66);
    chk("two_digest", hv[0], D_TWO);

    // start held high: back-to-back blocks every 66 cycles
    rst = 1'b1; tick; rst = 1'b0;
    uv = B_ABC; use_iv = 1'b1; hc = '0; start = 1'b1;
    nd = 0;
    for (int i = 1; i <= 200; i++) begin
      tick;
      exp_done = (i % 66) == 0;
      chk($sformatf("held_busy_done_c%0d", i), 256'({bz[0], dn[0]}), 256'({~exp_done, exp_done}));
      if (dn[0]) begin
        nd++;
        chk($sformatf("held_digest_c%0d", i), hv[0], D_ABC);
      end
    end
    start = 1'b0;
    chk("held_done_count", 256'(nd), 256'd3);

    // Reset abort in ROUND cycle 30; digest must stay stable until then
    rst = 1'b1; tick; rst = 1'b0;
    uv = B_ABC; use_iv = 1'b1; start = 1'b1;
    run_block(0, 100, 1'b0, lat);
    chk("pre_abort_digest", hv[0], D_ABC);
    uv = B_EMPTY; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 29; i++) tick;
    chk("digest_stable_in_flight", hv[0], D_ABC);
    chk("busy_in_flight", 256'(bz[0]), 256'd1);
    rst = 1'b1; tick; rst = 1'b0;
    chk("abort_busy", 256'(bz[0]), 256'd0);
    chk("abort_done", 256'(dn[0]), 256'd0);
    chk("abort_digest", hv[0], 256'd0);
    nd = 0;
    for (int i = 0; i < 80; i++) begin
      tick;
      if (dn[0] || bz[0]) nd++;
    end
    chk("abort_no_activity", 256'(nd), 256'd0);
    uv = B_ABC; use_iv = 1'b1; start = 1'b1;
    run_block(0, 100, 1'b0, lat);
    chk("post_abort_latency", 256'(lat), 256'd66);
    chk("post_abort_digest", hv[0], D_ABC);

    // start and rst together: start ignored
    tick;
    rst = 1'b1; start = 1'b1; tick; rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 256'(bz[0]), 256'd0);
    nd = 0;
    for (int i = 0; i < 70; i++) begin
      tick;
      if (dn[0] || bz[0]) nd++;
    end
    chk("rst_start_idle", 256'(nd), 256'd0);
    chk("rst_start_digest", hv[0], 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
